// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer
// Shares one status LED between two requesters. A fixed-priority arbiter
// (bit 0 wins) grants the LED, and the owner's blink sequence runs to
// completion: (repeats+1) blinks of on_ticks ON and off_ticks OFF, timed
// with a prescaled tick. A one-cycle ack goes to the owner at the end.

module led_blink_sequencer #(
   parameter int PRESCALE = 16384,
   parameter int TICK_W   = 5,
   parameter int REP_W    = 4
) (
   input  logic                  clk,
   input  logic                  i_reset_n,
   input  logic [1:0]            i_req,
   input  logic [2*TICK_W-1:0]   i_on_ticks,
   input  logic [2*TICK_W-1:0]   i_off_ticks,
   input  logic [2*REP_W-1:0]    i_repeats,
   output logic [1:0]            o_grant,
   output logic [1:0]            o_ack,
   output logic                  o_busy,
   output logic                  o_led
);

   localparam int PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ON,
      S_OFF,
      S_DONE
   } state_t;

   state_t              state;
   logic [PRE_W-1:0]    pre_cnt;
   logic [TICK_W-1:0]   tick_cnt;
   logic [REP_W-1:0]    blink_cnt;
   logic [TICK_W-1:0]   on_lat;
   logic [TICK_W-1:0]   off_lat;
   logic [REP_W-1:0]    rep_lat;

   logic                tick;
   logic                on_end;
   logic                off_end;
   logic [1:0]          grant_sel;
   logic [TICK_W-1:0]   on_sel;
   logic [TICK_W-1:0]   off_sel;
   logic [REP_W-1:0]    rep_sel;

   // Arbitration: pick the lowest-index requester and its config slices.
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      grant_sel = 2'b00;
      on_sel    = i_on_ticks[0 +: TICK_W];
      off_sel   = i_off_ticks[0 +: TICK_W];
      rep_sel   = i_repeats[0 +: REP_W];
      if (i_req[0]) begin
         grant_sel = 2'b01;
      end else if (i_req[1]) begin
         grant_sel = 2'b10;
         on_sel    = i_on_ticks[TICK_W +: TICK_W];
         off_sel   = i_off_ticks[TICK_W +: TICK_W];
         rep_sel   = i_repeats[REP_W +: REP_W];
      end
   end

   // Phase-end detection: a zero-length phase ends after one cycle, otherwise
   // on the tick where the tick count reaches the programmed length minus one.
   always_comb begin
      tick    = (pre_cnt == PRE_MAX);
      on_end  = (on_lat == '0)  || (tick && (tick_cnt == on_lat - 1'b1));
      off_end = (off_lat == '0) || (tick && (tick_cnt == off_lat - 1'b1));
   end

   // Sequencer FSM with registered outputs.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   // NOTE: the async reset clears every register, including latched config,
   // since there is no memory array here that would need to be left unreset.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= S_IDLE;
         pre_cnt   <= '0;
         tick_cnt  <= '0;
         blink_cnt <= '0;
         on_lat    <= '0;
         off_lat   <= '0;
         rep_lat   <= '0;
         o_grant   <= 2'b00;
         o_ack     <= 2'b00;
         o_busy    <= 1'b0;
         o_led     <= 1'b0;
      end else begin
         o_ack <= 2'b00;
         case (state)
            S_IDLE: begin
               if (grant_sel != 2'b00) begin
                  state     <= S_ON;
                  o_grant   <= grant_sel;
                  o_busy    <= 1'b1;
                  on_lat    <= on_sel;
                  off_lat   <= off_sel;
                  rep_lat   <= rep_sel;
                  pre_cnt   <= '0;
                  tick_cnt  <= '0;
                  blink_cnt <= '0;
                  o_led     <= (on_sel != '0);
               end
            end

            S_ON: begin
               if (on_end) begin
                  state    <= S_OFF;
                  pre_cnt  <= '0;
                  tick_cnt <= '0;
                  o_led    <= 1'b0;
               end else if (tick) begin
                  pre_cnt  <= '0;
                  tick_cnt <= tick_cnt + 1'b1;
               end else begin
                  pre_cnt  <= pre_cnt + 1'b1;
               end
            end

            S_OFF: begin
               if (off_end) begin
                  pre_cnt  <= '0;
                  tick_cnt <= '0;
                  if (blink_cnt == rep_lat) begin
                     state <= S_DONE;
                     o_ack <= o_grant;
                  end else begin
                     state     <= S_ON;
                     blink_cnt <= blink_cnt + 1'b1;
                     o_led     <= (on_lat != '0);
                  end
               end else if (tick) begin
                  pre_cnt  <= '0;
                  tick_cnt <= tick_cnt + 1'b1;
               end else begin
                  pre_cnt  <= pre_cnt + 1'b1;
               end
            end

            S_DONE: begin
               state   <= S_IDLE;
               o_grant <= 2'b00;
               o_busy  <= 1'b0;
               o_led   <= 1'b0;
            end

            default: begin
               state   <= S_IDLE;
               o_grant <= 2'b00;
               o_busy  <= 1'b0;
               o_led   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Testbench for led_blink_sequencer at PRESCALE=4.
// Table of single-requester sequences with hand-computed timing, followed by
// hand-written sequences for arbitration, config/req changes, regrant and
// asynchronous reset.

module tb_led_blink_sequencer;

   localparam int PRESCALE = 4;
   localparam int TICK_W   = 5;
   localparam int REP_W    = 4;
   localparam int LIMIT    = 5000;

   logic                  clk;
   logic                  i_reset_n;
   logic [1:0]            i_req;
   logic [2*TICK_W-1:0]   i_on_ticks;
   logic [2*TICK_W-1:0]   i_off_ticks;
   logic [2*REP_W-1:0]    i_repeats;
   logic [1:0]            o_grant;
   logic [1:0]            o_ack;
   logic                  o_busy;
   logic                  o_led;

   int checks = 0;
   int errors = 0;

   led_blink_sequencer #(
      .PRESCALE (PRESCALE),
      .TICK_W   (TICK_W),
      .REP_W    (REP_W)
   ) dut (
      .clk         (clk),
      .i_reset_n   (i_reset_n),
      .i_req       (i_req),
      .i_on_ticks  (i_on_ticks),
      .i_off_ticks (i_off_ticks),
      .i_repeats   (i_repeats),
      .o_grant     (o_grant),
      .o_ack       (o_ack),
      .o_busy      (o_busy),
      .o_led       (o_led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [1:0] req;
      int         on0, off0, rep0;
      int         on1, off1, rep1;
      logic [1:0] exp_grant;
      int         exp_cycles;   // edges from grant edge until ack is visible
      int         exp_high;     // cycles with led high
      int         exp_rises;    // number of blinks that lit the LED
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int on0, input int off0, input int rep0,
                          input int on1, input int off1, input int rep1);
      i_on_ticks  = {TICK_W'(on1), TICK_W'(on0)};
      i_off_ticks = {TICK_W'(off1), TICK_W'(off0)};
      i_repeats   = {REP_W'(rep1), REP_W'(rep0)};
   endtask

   // Called right after the grant edge; steps until ack is seen or limit hits.
   task automatic run_to_ack(output int k, output int high, output int rises);
      logic prev;
      k = 0; high = 0; rises = 0; prev = 1'b0;
      while (o_ack == 2'b00 && k < LIMIT) begin
         if (o_led) high++;
         if (o_led && !prev) rises++;
         prev = o_led;
         step();
         k++;
      end
   endtask

   int k, high, rises, bad;

   initial begin
      vecs[0] = '{"basic_r0",   2'b01,  2,  1,  0,  9,  9,  9, 2'b01,   12,    8,  1};
      vecs[1] = '{"basic_r1",   2'b10,  7,  7,  7,  3,  2,  1, 2'b10,   40,   24,  2};
      vecs[2] = '{"zero_r0",    2'b01,  0,  0,  2,  5,  5,  5, 2'b01,    6,    0,  0};
      vecs[3] = '{"off0_r1",    2'b10,  6,  6,  6,  1,  0,  2, 2'b10,   15,   12,  3};
      vecs[4] = '{"max_r0",     2'b01, 31, 31, 15,  1,  1,  1, 2'b01, 3968, 1984, 16};
      vecs[5] = '{"on0_r1",     2'b10,  3,  3,  3,  0,  5,  0, 2'b10,   21,    0,  0};

      i_reset_n = 1'b0;
      i_req     = 2'b00;
      set_cfg(0, 0, 0, 0, 0, 0);
      #22;
      check("reset_grant", o_grant, 2'b00);
      check("reset_ack",   o_ack,   2'b00);
      check("reset_busy",  o_busy,  1'b0);
      check("reset_led",   o_led,   1'b0);
      i_reset_n = 1'b1;
      step();
      step();
      check("idle_busy", o_busy, 1'b0);

      // Table-driven single-requester sequences.
      for (int v = 0; v < 6; v++) begin
         set_cfg(vecs[v].on0, vecs[v].off0, vecs[v].rep0,
                 vecs[v].on1, vecs[v].off1, vecs[v].rep1);
         i_req = vecs[v].req;
         step();
         check({vecs[v].name, "_grant"}, o_grant, vecs[v].exp_grant);
         check({vecs[v].name, "_busy"},  o_busy,  1'b1);
         run_to_ack(k, high, rises);
         check({vecs[v].name, "_cycles"}, k,     vecs[v].exp_cycles);
         check({vecs[v].name, "_high"},   high,  vecs[v].exp_high);
         check({vecs[v].name, "_rises"},  rises, vecs[v].exp_rises);
         check({vecs[v].name, "_ack"},    o_ack, vecs[v].exp_grant);
         check({vecs[v].name, "_done_led"},   o_led,   1'b0);
         check({vecs[v].name, "_done_grant"}, o_grant, vecs[v].exp_grant);
         i_req = 2'b00;
         step();
         check({vecs[v].name, "_idle_ack"},   o_ack,   2'b00);
         check({vecs[v].name, "_idle_busy"},  o_busy,  1'b0);
         check({vecs[v].name, "_idle_grant"}, o_grant, 2'b00);
      end

      // Simultaneous requests: bit 0 first, bit 1 after one IDLE cycle.
      set_cfg(1, 1, 1, 1, 1, 1);
      i_req = 2'b11;
      step();
      check("simul_grant0", o_grant, 2'b01);
      run_to_ack(k, high, rises);
      check("simul_cycles0", k, 16);
      check("simul_ack0", o_ack, 2'b01);
      i_req = 2'b10;
      step();
      check("simul_idle_grant", o_grant, 2'b00);
      step();
      check("simul_grant1", o_grant, 2'b10);
      run_to_ack(k, high, rises);
      check("simul_cycles1", k, 16);
      check("simul_ack1", o_ack, 2'b10);
      i_req = 2'b00;
      step();
      step();

      // No preemption: req[0] rises while requester 1 owns the LED.
      set_cfg(2, 2, 0, 1, 1, 0);
      i_req = 2'b10;
      step();
      bad = 0;
      k = 0;
      while (o_ack == 2'b00 && k < LIMIT) begin
         if (k == 2) i_req = 2'b11;
         if (o_grant != 2'b10) bad++;
         step();
         k++;
      end
      check("nopre_grant_held", bad, 0);
      check("nopre_cycles", k, 8);
      check("nopre_ack", o_ack, 2'b10);
      i_req = 2'b01;
      step();
      check("nopre_idle_grant", o_grant, 2'b00);
      step();
      check("nopre_next_grant", o_grant, 2'b01);
      i_req = 2'b00;
      run_to_ack(k, high, rises);
      check("nopre_r0_cycles", k, 16);
      step();
      step();

      // Config change and req drop mid-sequence: timing unchanged, ack issued.
      set_cfg(2, 1, 1, 0, 0, 0);
      i_req = 2'b01;
      step();
      k = 0; high = 0;
      while (o_ack == 2'b00 && k < LIMIT) begin
         if (k == 3) begin
            i_req = 2'b00;
            set_cfg(7, 9, 5, 7, 9, 5);
         end
         if (o_led) high++;
         step();
         k++;
      end
      check("chg_cycles", k, 24);
      check("chg_high", high, 16);
      check("chg_ack", o_ack, 2'b01);
      step();
      step();

      // Req held through ack: regrant one IDLE cycle after DONE.
      set_cfg(1, 0, 0, 0, 0, 0);
      i_req = 2'b01;
      step();
      run_to_ack(k, high, rises);
      check("regrant_cycles", k, 5);
      check("regrant_ack", o_ack, 2'b01);
      step();
      check("regrant_idle_grant", o_grant, 2'b00);
      check("regrant_idle_busy", o_busy, 1'b0);
      step();
      check("regrant_grant", o_grant, 2'b01);
      check("regrant_busy", o_busy, 1'b1);
      i_req = 2'b00;
      run_to_ack(k, high, rises);
      check("regrant2_cycles", k, 5);
      step();
      step();

      // Asynchronous reset mid-ON: outputs clear between edges, no ack.
      set_cfg(5, 1, 0, 0, 0, 0);
      i_req = 2'b01;
      step();
      step();
      step();
      check("rst_pre_led", o_led, 1'b1);
      #3;
      i_reset_n = 1'b0;
      #1;
      check("rst_led",   o_led,   1'b0);
      check("rst_grant", o_grant, 2'b00);
      check("rst_busy",  o_busy,  1'b0);
      check("rst_ack",   o_ack,   2'b00);
      i_req = 2'b00;
      step();
      i_reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         if (o_ack != 2'b00 || o_busy || o_grant != 2'b00 || o_led) bad++;
         step();
      end
      check("rst_stays_idle", bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
